// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and constants for the reset sequencer
// Purpose: sequencer state encoding, domain count and default timing values.
// Ports: none (package).
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_IDLE    = 2'd3
    } state_t;

    localparam int NUM_DOMAINS     = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_STAGGER     = 2;

endpackage

// File: rtl/rst_seq_8bit_if.sv
// rtl/rst_seq_8bit_if.sv - soft-reset request and per-domain reset outputs
// Purpose: bundles the sequencer's request/status signals.
// Signals: req (soft-reset pulse), rst_out[7:0] (per-domain resets),
//          busy (sequence in progress), done (last domain released pulse).
// Modports: master drives req and observes status; slave is the sequencer.
interface rst_seq_8bit_if;

    logic                                 req;
    logic [rst_seq_pkg::NUM_DOMAINS-1:0]  rst_out;
    logic                                 busy;
    logic                                 done;

    modport master (
        output req,
        input  rst_out,
        input  busy,
        input  done
    );

    modport slave (
        input  req,
        output rst_out,
        output busy,
        output done
    );

endinterface

// File: rtl/rst_sync_chain.sv
// rtl/rst_sync_chain.sv - async-assert, sync-deassert reset synchroniser
// Purpose: every stage is set by rst and shifts in 0, so rst_s rises with rst
//          and falls on the STAGES-th rising clk edge after rst is removed.
// Ports: clk (clock), rst (async active-high reset), rst_s (synchronised reset).
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_s
);

    if (STAGES < 2) begin : g_bad_stages
        $fatal(1, "rst_sync_chain: STAGES must be >= 2");
    end

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign rst_s = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_8bit.sv
// rtl/rst_seq_8bit.sv - staggered eight-domain reset sequencer
// Purpose: holds all domain resets after a synchronised rst release, then
//          releases domain 0..7 one at a time; req restarts the hold phase.
// Ports: clk (clock), rst (async active-high reset),
//        bus (slave modport: req in; rst_out, busy, done out).
module rst_seq_8bit
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGGER     = DEF_STAGGER
) (
    input  logic          clk,
    input  logic          rst,
    rst_seq_8bit_if.slave bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "rst_seq_8bit: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "rst_seq_8bit: HOLD_CYCLES must be >= 1");
    end
    if (STAGGER < 1) begin : g_bad_stagger
        $fatal(1, "rst_seq_8bit: STAGGER must be >= 1");
    end

    localparam int CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam int TICK_W = $clog2(STAGGER + 1);
    localparam int STEP_W = $clog2(NUM_DOMAINS);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STAGGER - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_DOMAINS - 1);

    logic rst_s;

    rst_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .rst_s (rst_s)
    );

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [TICK_W-1:0]      tick, tick_n;
    logic [STEP_W-1:0]      step, step_n;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_n;
    logic                   done_q, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            tick      <= '0;
            step      <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tick      <= tick_n;
            step      <= step_n;
            rst_out_q <= rst_out_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tick_n    = tick;
        step_n    = step;
        rst_out_n = rst_out_q;
        done_n    = 1'b0;

        unique case (state)
            ST_ASSERT: begin
                // req is deliberately ignored until the synchronised release.
                rst_out_n = '1;
                if (!rst_s) begin
                    state_n = ST_HOLD;
                    cnt_n   = '0;
                end
            end
            ST_HOLD: begin
                rst_out_n = '1;
                if (bus.req) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_RELEASE;
                    tick_n  = '0;
                    step_n  = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // A req on a release edge takes priority: nothing is cleared.
                if (bus.req) begin
                    state_n   = ST_HOLD;
                    cnt_n     = '0;
                    tick_n    = '0;
                    step_n    = '0;
                    rst_out_n = '1;
                end else if (tick != TICK_LAST) begin
                    tick_n = tick + TICK_W'(1);
                end else begin
                    rst_out_n[step] = 1'b0;
                    tick_n          = '0;
                    if (step == STEP_LAST) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        step_n = step + STEP_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                rst_out_n = '0;
                if (bus.req) begin
                    state_n   = ST_HOLD;
                    cnt_n     = '0;
                    tick_n    = '0;
                    step_n    = '0;
                    rst_out_n = '1;
                end
            end
            default: begin
                state_n   = ST_ASSERT;
                rst_out_n = '1;
            end
        endcase
    end

    assign bus.rst_out = rst_out_q;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_rst_seq_8bit.sv
// tb/tb_rst_seq_8bit.sv - self-checking bench for rst_seq_8bit
module tb_rst_seq_8bit;

    localparam int SY  = 2;
    localparam int H   = 4;
    localparam int S   = 2;
    localparam int SY2 = 3;
    localparam int H2  = 1;
    localparam int S2  = 1;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   edge_cnt = 0;
    int   tests = 0;
    int   fails = 0;

    rst_seq_8bit_if bus();
    rst_seq_8bit_if bus2();

    rst_seq_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rst_seq_8bit #(
        .SYNC_STAGES (SY2),
        .HOLD_CYCLES (H2),
        .STAGGER     (S2)
    ) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference timeline: hs is the edge on which the hold phase begins.
    // The hold spans h edges, then one domain is released every s edges.
    function automatic logic [7:0] m_out(int e, int hs, int h, int s);
        logic [7:0] ones;
        int k;
        ones = 8'hFF;
        if (e < hs + h + s) return ones;
        k = (e - hs - h) / s;
        if (k > 8) k = 8;
        return ones << k;
    endfunction

    function automatic logic m_busy(int e, int hs, int h, int s);
        return (e < hs + h + 8 * s);
    endfunction

    function automatic logic m_done(int e, int hs, int h, int s);
        return (e == hs + h + 8 * s);
    endfunction

    task automatic test_reset();
        rst  = 1'b0;
        rst2 = 1'b0;
        bus.req  = 1'b0;
        bus2.req = 1'b0;
        #1;
        rst  = 1'b1;
        rst2 = 1'b1;
        #1;
        if (bus.rst_out !== 8'hFF || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rst_out=%h busy=%b done=%b, expected ff 1 0",
                     bus.rst_out, bus.busy, bus.done);
        end
        tests++;
        if (bus2.rst_out !== 8'hFF || bus2.busy !== 1'b1 || bus2.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state_sweep: rst_out=%h busy=%b done=%b, expected ff 1 0",
                     bus2.rst_out, bus2.busy, bus2.done);
        end
        tests++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_power_on();
        int e0, hs, e;
        rst = 1'b0;
        e0 = edge_cnt;
        hs = e0 + 1 + SY;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            e = edge_cnt;
            if (bus.rst_out !== m_out(e, hs, H, S) || bus.busy !== m_busy(e, hs, H, S) ||
                bus.done !== m_done(e, hs, H, S)) begin
                fails++;
                $display("FAIL power_on E%0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                         e - e0, bus.rst_out, bus.busy, bus.done,
                         m_out(e, hs, H, S), m_busy(e, hs, H, S), m_done(e, hs, H, S));
            end
            tests++;
        end
    endtask

    task automatic test_async_reset();
        int e0, hs, e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e0 = edge_cnt;
        hs = e0 + 1 + SY;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            e = edge_cnt;
            if (bus.rst_out !== m_out(e, hs, H, S) || bus.busy !== m_busy(e, hs, H, S)) begin
                fails++;
                $display("FAIL async_pre E%0d: rst_out=%h busy=%b, expected %h %b",
                         e - e0, bus.rst_out, bus.busy, m_out(e, hs, H, S), m_busy(e, hs, H, S));
            end
            tests++;
        end
        e = edge_cnt;
        #2;
        rst = 1'b1;
        #1;
        if (bus.rst_out !== 8'hFF || bus.busy !== 1'b1 || bus.done !== 1'b0 || edge_cnt != e) begin
            fails++;
            $display("FAIL async_assert: rst_out=%h busy=%b done=%b edges=%0d, expected ff 1 0 %0d",
                     bus.rst_out, bus.busy, bus.done, edge_cnt, e);
        end
        tests++;
        @(negedge clk);
        rst = 1'b0;
        e0 = edge_cnt;
        hs = e0 + 1 + SY;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            e = edge_cnt;
            if (bus.rst_out !== m_out(e, hs, H, S) || bus.busy !== m_busy(e, hs, H, S) ||
                bus.done !== m_done(e, hs, H, S)) begin
                fails++;
                $display("FAIL async_repeat E%0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                         e - e0, bus.rst_out, bus.busy, bus.done,
                         m_out(e, hs, H, S), m_busy(e, hs, H, S), m_done(e, hs, H, S));
            end
            tests++;
        end
    endtask

    task automatic test_req_idle();
        int hs, e, ek;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        bus.req = 1'b1;
        ek = edge_cnt + 1;
        hs = ek;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            bus.req = 1'b0;
            e = edge_cnt;
            if (bus.rst_out !== m_out(e, hs, H, S) || bus.busy !== m_busy(e, hs, H, S) ||
                bus.done !== m_done(e, hs, H, S)) begin
                fails++;
                $display("FAIL req_idle Ek+%0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                         e - ek, bus.rst_out, bus.busy, bus.done,
                         m_out(e, hs, H, S), m_busy(e, hs, H, S), m_done(e, hs, H, S));
            end
            tests++;
        end
    endtask

    task automatic test_req_release();
        int hs, e, tgt, b;
        bit fired;
        for (int r = 0; r < 3; r++) begin
            b = (r == 0) ? 3 : int'($urandom_range(0, 7));
            bus.req = 1'b1;
            hs = edge_cnt + 1;
            tgt = hs + H + S * (b + 1);
            fired = 1'b0;
            for (int i = 0; i < 80; i++) begin
                if (!fired && edge_cnt == tgt - 1) begin
                    bus.req = 1'b1;
                    hs = tgt;
                    fired = 1'b1;
                end
                @(negedge clk);
                bus.req = 1'b0;
                e = edge_cnt;
                if (bus.rst_out !== m_out(e, hs, H, S) || bus.busy !== m_busy(e, hs, H, S) ||
                    bus.done !== m_done(e, hs, H, S)) begin
                    fails++;
                    $display("FAIL req_release bit%0d e=%0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                             b, e, bus.rst_out, bus.busy, bus.done,
                             m_out(e, hs, H, S), m_busy(e, hs, H, S), m_done(e, hs, H, S));
                end
                tests++;
                if (fired && e >= hs + H + 8 * S + 1) break;
            end
        end
    endtask

    task automatic test_req_hold();
        int hs, e, e0, tgt, off, p;
        bit fired;
        for (int r = 0; r < 2; r++) begin
            off = (r == 0) ? 2 : int'($urandom_range(1, 3));
            bus.req = 1'b1;
            hs = edge_cnt + 1;
            tgt = hs + off;
            fired = 1'b0;
            for (int i = 0; i < 60; i++) begin
                if (!fired && edge_cnt == tgt - 1) begin
                    bus.req = 1'b1;
                    hs = tgt;
                    fired = 1'b1;
                end
                @(negedge clk);
                bus.req = 1'b0;
                e = edge_cnt;
                if (bus.rst_out !== m_out(e, hs, H, S) || bus.busy !== m_busy(e, hs, H, S) ||
                    bus.done !== m_done(e, hs, H, S)) begin
                    fails++;
                    $display("FAIL req_hold off%0d e=%0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                             off, e, bus.rst_out, bus.busy, bus.done,
                             m_out(e, hs, H, S), m_busy(e, hs, H, S), m_done(e, hs, H, S));
                end
                tests++;
                if (fired && e >= hs + H + 8 * S + 1) break;
            end
        end
        // req while still in ASSERT must not move the timeline.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e0 = edge_cnt;
        hs = e0 + 1 + SY;
        p = int'($urandom_range(1, 3));
        for (int i = 0; i < 26; i++) begin
            if (edge_cnt == e0 + p - 1) bus.req = 1'b1;
            @(negedge clk);
            bus.req = 1'b0;
            e = edge_cnt;
            if (bus.rst_out !== m_out(e, hs, H, S) || bus.busy !== m_busy(e, hs, H, S) ||
                bus.done !== m_done(e, hs, H, S)) begin
                fails++;
                $display("FAIL req_assert E%0d (req E%0d): rst_out=%h busy=%b done=%b, expected %h %b %b",
                         e - e0, p, bus.rst_out, bus.busy, bus.done,
                         m_out(e, hs, H, S), m_busy(e, hs, H, S), m_done(e, hs, H, S));
            end
            tests++;
        end
    endtask

    task automatic test_back_to_back();
        int hs, e, nxt, left;
        bit finished;
        nxt = edge_cnt + 1;
        hs = nxt;
        left = 6;
        finished = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (left > 0 && edge_cnt == nxt - 1) begin
                bus.req = 1'b1;
                hs = nxt;
                left--;
                nxt = nxt + ((left == 5) ? 1 : int'($urandom_range(1, 26)));
            end
            @(negedge clk);
            bus.req = 1'b0;
            e = edge_cnt;
            if (bus.rst_out !== m_out(e, hs, H, S) || bus.busy !== m_busy(e, hs, H, S) ||
                bus.done !== m_done(e, hs, H, S)) begin
                fails++;
                $display("FAIL back_to_back e=%0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                         e, bus.rst_out, bus.busy, bus.done,
                         m_out(e, hs, H, S), m_busy(e, hs, H, S), m_done(e, hs, H, S));
            end
            tests++;
            if (left == 0 && e >= hs + H + 8 * S + 1) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            fails++;
            $display("FAIL back_to_back_timeout: sequence not complete, edge=%0d", edge_cnt);
        end
        tests++;
    endtask

    task automatic test_param_sweep();
        int e0, hs, e;
        rst2 = 1'b0;
        e0 = edge_cnt;
        hs = e0 + 1 + SY2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = edge_cnt;
            if (bus2.rst_out !== m_out(e, hs, H2, S2) || bus2.busy !== m_busy(e, hs, H2, S2) ||
                bus2.done !== m_done(e, hs, H2, S2)) begin
                fails++;
                $display("FAIL param_sweep E%0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                         e - e0, bus2.rst_out, bus2.busy, bus2.done,
                         m_out(e, hs, H2, S2), m_busy(e, hs, H2, S2), m_done(e, hs, H2, S2));
            end
            tests++;
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_async_reset();
        test_req_idle();
        test_req_release();
        test_req_hold();
        test_back_to_back();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
